// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the operand-fetch stage and its forwarding muxes.
//   CTRL_W_DEFAULT - default width of the decoded control bundle
//   CNT_W_DEFAULT  - default width of the stall counter
//   state_t        - ID/EX sequencing states
//   fwd_sel_t      - operand source selected by a forwarding mux
package pipe_pkg;

    localparam int CTRL_W_DEFAULT = 16;
    localparam int CNT_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2,
        REG  = 2'd3
    } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: resolves one source operand from the register file or a bypass path.
//   rs                      - source register index
//   mem_write/rd/result     - EX/MEM bypass source (highest priority)
//   wb_write/rd/data        - MEM/WB bypass source
//   reg_data                - register-file read data
//   operand                 - resolved operand value
module fwd_mux
    import pipe_pkg::*;
(
    input  logic [4:0]  rs,
    input  logic        mem_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [31:0] reg_data,
    output logic [31:0] operand
);

    fwd_sel_t sel;

    // x0 is hardwired to zero, so it never takes a bypass even if a write
    // to x0 is in flight. The younger MEM result wins over WB.
    always_comb begin
        sel = REG;
        if (rs == 5'd0) begin
            sel = ZERO;
        end else if (mem_write && (mem_rd == rs)) begin
            sel = MEM;
        end else if (wb_write && (wb_rd == rs)) begin
            sel = WB;
        end
    end

    always_comb begin
        operand = reg_data;
        case (sel)
            ZERO:    operand = 32'd0;
            MEM:     operand = mem_result;
            WB:      operand = wb_data;
            default: operand = reg_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: ID/EX pipeline register with operand forwarding, load-use
// bubble insertion, downstream back-pressure and flush.
//   CLK, RESET (async, active-low)
//   ID_*          - instruction currently in decode
//   OUT1/2ADDRESS - register-file read addresses; REG_DATA1/2 - read data
//   MEM_*, WB_*   - bypass sources from EX/MEM and MEM/WB
//   EX_READY      - downstream accepts; FLUSH - kill decode and ID/EX
//   ID_STALL      - decode must hold its instruction
//   EX_*          - registered instruction presented to execute
//   STALL_CNT     - saturating count of stalled cycles
module operand_fetch
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ID_VALID,
    input  logic [4:0]        ID_RS1,
    input  logic [4:0]        ID_RS2,
    input  logic [4:0]        ID_RD,
    input  logic [31:0]       ID_PC,
    input  logic [31:0]       ID_IMM,
    input  logic [CTRL_W-1:0] ID_CTRL,
    input  logic              ID_ISLOAD,
    output logic [4:0]        OUT1ADDRESS,
    output logic [4:0]        OUT2ADDRESS,
    input  logic [31:0]       REG_DATA1,
    input  logic [31:0]       REG_DATA2,
    input  logic              MEM_WRITE,
    input  logic [4:0]        MEM_RD,
    input  logic [31:0]       MEM_RESULT,
    input  logic              WB_WRITE,
    input  logic [4:0]        WB_RD,
    input  logic [31:0]       WB_DATA,
    input  logic              EX_READY,
    input  logic              FLUSH,
    output logic              ID_STALL,
    output logic              EX_VALID,
    output logic [31:0]       EX_OP1,
    output logic [31:0]       EX_OP2,
    output logic [4:0]        EX_RD,
    output logic [31:0]       EX_PC,
    output logic [31:0]       EX_IMM,
    output logic [CTRL_W-1:0] EX_CTRL,
    output logic              EX_ISLOAD,
    output logic [CNT_W-1:0]  STALL_CNT
);

    state_t      state;
    state_t      next_state;
    logic        stall_req;
    logic        load_en;
    logic        kill;
    logic        load_use;
    logic [31:0] op1;
    logic [31:0] op2;

    assign OUT1ADDRESS = ID_RS1;
    assign OUT2ADDRESS = ID_RS2;

    fwd_mux u_fwd1 (
        .rs        (ID_RS1),
        .mem_write (MEM_WRITE),
        .mem_rd    (MEM_RD),
        .mem_result(MEM_RESULT),
        .wb_write  (WB_WRITE),
        .wb_rd     (WB_RD),
        .wb_data   (WB_DATA),
        .reg_data  (REG_DATA1),
        .operand   (op1)
    );

    fwd_mux u_fwd2 (
        .rs        (ID_RS2),
        .mem_write (MEM_WRITE),
        .mem_rd    (MEM_RD),
        .mem_result(MEM_RESULT),
        .wb_write  (WB_WRITE),
        .wb_rd     (WB_RD),
        .wb_data   (WB_DATA),
        .reg_data  (REG_DATA2),
        .operand   (op2)
    );

    // A load in EX cannot supply its data until it reaches MEM, so a
    // dependent instruction in decode must wait one cycle.
    assign load_use = ID_VALID && EX_VALID && EX_ISLOAD && (EX_RD != 5'd0) &&
                      ((EX_RD == ID_RS1) || (EX_RD == ID_RS2));

    // Flush wins over everything. In HOLD nothing moves until EX_READY
    // returns; after that the cycle is handled exactly like RUN.
    always_comb begin
        next_state = state;
        stall_req  = 1'b0;
        load_en    = 1'b0;
        kill       = 1'b0;
        if (FLUSH) begin
            kill       = 1'b1;
            next_state = RUN;
        end else if (state == BUBBLE) begin
            load_en    = 1'b1;
            next_state = RUN;
        end else if ((state == HOLD) && !EX_READY) begin
            stall_req  = 1'b1;
            next_state = HOLD;
        end else if (load_use) begin
            kill       = 1'b1;
            stall_req  = 1'b1;
            next_state = BUBBLE;
        end else if (!EX_READY && EX_VALID) begin
            stall_req  = 1'b1;
            next_state = HOLD;
        end else begin
            load_en    = 1'b1;
            next_state = RUN;
        end
    end

    assign ID_STALL = stall_req && RESET;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // A bubble or flush only clears the valid bit; payload fields are
    // don't-care while EX_VALID is low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            EX_VALID  <= 1'b0;
            EX_OP1    <= 32'd0;
            EX_OP2    <= 32'd0;
            EX_RD     <= 5'd0;
            EX_PC     <= 32'd0;
            EX_IMM    <= 32'd0;
            EX_CTRL   <= '0;
            EX_ISLOAD <= 1'b0;
        end else if (load_en) begin
            EX_VALID  <= ID_VALID;
            EX_OP1    <= op1;
            EX_OP2    <= op2;
            EX_RD     <= ID_RD;
            EX_PC     <= ID_PC;
            EX_IMM    <= ID_IMM;
            EX_CTRL   <= ID_CTRL;
            EX_ISLOAD <= ID_ISLOAD;
        end else if (kill) begin
            EX_VALID  <= 1'b0;
        end
    end

    // Saturates instead of wrapping so a long stall never reads as a short one.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            STALL_CNT <= '0;
        end else if (ID_STALL && (STALL_CNT != '1)) begin
            STALL_CNT <= STALL_CNT + CNT_W'(1);
        end
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of decoded control bundle.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-003 SHALL have ports CLK input 1 (single clock) and RESET input 1, where reset is asynchronous and active-low.
REQ-004 SHALL have ports ID_VALID in 1, ID_RS1 in 5, ID_RS2 in 5, ID_RD in 5, ID_PC in 32, ID_IMM in 32, ID_CTRL in CTRL_W, ID_ISLOAD in 1 (instruction in decode).
REQ-005 SHALL have ports OUT1ADDRESS out 5, OUT2ADDRESS out 5 (register-file read addresses) and REG_DATA1 in 32, REG_DATA2 in 32 (register-file read data).
REQ-006 SHALL have ports MEM_WRITE in 1, MEM_RD in 5, MEM_RESULT in 32 (EX/MEM forward source).
REQ-007 SHALL have ports WB_WRITE in 1, WB_RD in 5, WB_DATA in 32 (MEM/WB source, same values driven to register-file write port).
REQ-008 SHALL have ports EX_READY in 1 (downstream accepts) and FLUSH in 1 (kill decode and ID/EX contents).
REQ-009 SHALL have ports ID_STALL out 1, EX_VALID out 1, EX_OP1 out 32, EX_OP2 out 32, EX_RD out 5, EX_PC out 32, EX_IMM out 32, EX_CTRL out CTRL_W, EX_ISLOAD out 1, STALL_CNT out CNT_W.

Function
REQ-010 SHALL drive OUT1ADDRESS=ID_RS1 and OUT2ADDRESS=ID_RS2 combinationally.
REQ-011 SHALL resolve each operand combinationally: rs==0 gives 0; else MEM match (MEM_WRITE, MEM_RD==rs) gives MEM_RESULT; else WB match gives WB_DATA; else REG_DATA.
REQ-012 SHALL give MEM priority over WB when both match the same rs.
REQ-013 SHALL detect load-use: ID_VALID, EX_VALID, EX_ISLOAD, EX_RD!=0, EX_RD equal to ID_RS1 or ID_RS2.
REQ-014 SHALL implement FSM states RUN, BUBBLE, HOLD.
REQ-015 RUN: on load-use, load bubble (EX_VALID<=0), assert ID_STALL, go BUBBLE; on EX_READY=0 with EX_VALID=1, keep register, assert ID_STALL, go HOLD; else load ID fields, EX_VALID<=ID_VALID.
REQ-016 BUBBLE: exactly one bubble cycle; ID_STALL deasserted; load ID fields (load now forwarded via MEM); return RUN.
REQ-017 HOLD: keep all EX_* outputs stable, ID_STALL=1, until EX_READY=1, then behave as RUN that cycle.
REQ-018 SHALL load ID/EX register only when ID_STALL=0 or in BUBBLE; EX_VALID=0 when ID_VALID=0.
REQ-019 FLUSH SHALL override all: EX_VALID<=0, ID_STALL=0, state<=RUN, regardless of load-use or EX_READY.
REQ-020 STALL_CNT SHALL increment each cycle ID_STALL=1 and saturate at all-ones, no wrap.
REQ-021 Latency: one cycle from ID acceptance to EX_* valid.

Reset
REQ-022 RESET low SHALL immediately force EX_VALID=0, EX_OP1/OP2/PC/IMM=0, EX_RD=0, EX_CTRL=0, EX_ISLOAD=0, STALL_CNT=0, state RUN.
REQ-023 ID_STALL SHALL be 0 during reset; reset release mid-stall resumes in RUN.

Structure
REQ-024 SHALL place FSM state encoding, forward-select enum (ZERO, MEM, WB, REG) and CTRL_W default in shared package pipe_pkg.
REQ-025 SHALL instantiate sub-module fwd_mux twice, one per operand.

Verification
REQ-026 WB_WRITE=1, WB_RD=5, WB_DATA=0x0000_00AA, ID_RS1=5, REG_DATA1=0 -> EX_OP1=0xAA next cycle.
REQ-027 MEM_RD=WB_RD=3, MEM_RESULT=0x11, WB_DATA=0x22, ID_RS2=3 -> EX_OP2=0x11.
REQ-028 Load to x7 in EX, ID_RS1=7 -> one bubble (EX_VALID=0), ID_STALL=1 one cycle, then EX_OP1=MEM_RESULT, STALL_CNT=1.
REQ-029 ID_RS1=0, MEM_WRITE=1, MEM_RD=0, MEM_RESULT=0xFFFF_FFFF -> EX_OP1=0; load to x0 causes no stall.
REQ-030 EX_READY=0 for 3 cycles -> EX_* stable, ID_STALL=1; FLUSH in cycle 2 -> EX_VALID=0 next cycle, state RUN.
REQ-031 RESET low mid-HOLD -> all outputs zero immediately, STALL_CNT=0.
